soc1_ram_arbiter: RTL and testbench
===================================

// Module: soc1_ram_arbiter
// PURPOSE
//  Two-master arbiter that shares the single-port 512x32 on-chip RAM (byte-enabled, address registered
//  on clk, read data valid the cycle after address) between two Avalon-MM style requesters (m0, m1).
//  Sits between the masters and the RAM. Drives address/byteenable/chipselect/write/writedata/clken.
//  Returns waitrequest and readdatavalid per master. Bounded ownership hold prevents starvation.
// PARAMETERS
//  ADDR_W    9   word address width (RAM depth 2**ADDR_W)
//  DATA_W    32  data width; byteenable width is DATA_W/8
//  HOLD_MAX  4   max consecutive beats an owner keeps the RAM while the other master waits (1..15)
// PORTS
//  clk                 in   1         system clock, all logic on rising edge
//  reset               in   1         synchronous, active-high reset
//  m0_address          in   ADDR_W    master 0 word address
//  m0_byteenable       in   DATA_W/8  master 0 byte lanes (write only)
//  m0_read             in   1         master 0 read request
//  m0_write            in   1         master 0 write request
//  m0_writedata        in   DATA_W    master 0 write data
//  m0_waitrequest      out  1         1 = master 0 request not accepted this cycle
//  m0_readdatavalid    out  1         master 0 read data valid on m0_readdata
//  m0_readdata         out  DATA_W    = ram_readdata
//  m1_*                --   --        identical set for master 1
//  ram_address         out  ADDR_W    to RAM
//  ram_byteenable      out  DATA_W/8  to RAM; all-ones on reads
//  ram_chipselect      out  1         1 only in a cycle with an accepted transfer
//  ram_write           out  1         1 only for an accepted write
//  ram_writedata       out  DATA_W    to RAM
//  ram_clken           out  1         constant 1
//  ram_readdata        in   DATA_W    RAM q output, valid 1 cycle after accepted read
// BEHAVIOUR
//  - req_i = mi_read | mi_write. If both are high, it is a write; no readdatavalid is issued.
//  - FSM states IDLE, OWN0, OWN1. beat_cnt counts accepted beats of the current owner.
//  - IDLE: no master has waitrequest low. Next state: OWN0 if req0, else OWN1 if req1 (fixed priority).
//  - OWNi: mi_waitrequest = 0 while state == OWNi. A transfer is accepted in each cycle with req_i = 1.
//    RAM outputs are driven combinationally from master i, and beat_cnt increments.
//  - Leaving OWNi: if req_i = 0 this cycle, go to OWNj if req_j, else IDLE.
//    If this beat brings beat_cnt to HOLD_MAX and req_j = 1, go to OWNj.
//    Otherwise stay in OWNi. At HOLD_MAX with req_j = 0, the owner keeps going and beat_cnt saturates.
//  - beat_cnt clears to 0 on every state change.
//  - Non-owner waitrequest = 1 whenever its req is high. Waitrequest is don't-care when req is low;
//    the block drives 1.
//  - Arbitration latency: 1 idle cycle from IDLE to first accept. Owner-to-owner handover is zero-bubble:
//    the new owner is accepted in the cycle after the old owner's last beat.
//  - Reads: rd_pend_i <= accepted read by master i.
//    mi_readdatavalid = rd_pend_i, giving exactly 1 cycle of read latency.
//    Data is not buffered; masters must sample it in that cycle.
//  - Idle RAM outputs: chipselect = 0, write = 0. Address, byteenable and writedata hold the last owner's values.
//  - Reset (sync): state IDLE, beat_cnt 0, rd_pend 0, both readdatavalid 0, both waitrequest 1,
//    ram_chipselect 0, ram_write 0.
//    Reset during a transfer drops any pending readdatavalid. A write accepted in the reset cycle is
//    not issued, because chipselect is forced to 0.
// CONFIGURATION
//  RAM_ARB_ROUND_ROBIN_EN defined: a last_owner register (reset 1) sets priority in IDLE.
//    The master other than last_owner wins a tie.
//  Not defined: fixed priority, and m0 always wins in IDLE. HOLD_MAX handover is unchanged in both modes.
// TESTING
//  1. m0 writes 0xDEADBEEF to address 0x005 with byteenable 0xF, then reads 0x005.
//     -> readdatavalid high exactly 1 cycle after the read accept, data 0xDEADBEEF.
//  2. m0 writes 0xFFFFFFFF to 0x010, then writes 0x12345678 with byteenable 0x3. -> read of 0x010 returns 0xFFFF5678.
//  3. HOLD_MAX = 4, both masters request continuously from IDLE. -> accept pattern 4x m0, 4x m1, 4x m0.
//     No idle cycle between owners.
//  4. m1 is the only requester for 10 reads. -> waitrequest is 1 for the first cycle only.
//     Then 10 consecutive accepts and 10 consecutive readdatavalids.
//  5. Reset is pulsed in the cycle after an m0 read accept. -> m0_readdatavalid stays 0, FSM is IDLE,
//     both waitrequest = 1 during reset.
//  6. m0 is served, then both masters go idle, then both request in the same cycle.
//     -> with RAM_ARB_ROUND_ROBIN_EN, m1 is granted first. Without it, m0 is granted first.

Source files
------------

// File: rtl/soc1_ram_arbiter_if.sv
// Avalon-MM style requester bundle for one master port of the RAM arbiter.
// Latency: none, wires only.
// Backpressure: waitrequest from the arbiter side stalls the requester.
interface soc1_ram_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic                readdatavalid;
  logic [DATA_W-1:0]   readdata;

  // Requester side: issues commands, sees stall and read return.
  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdatavalid, readdata
  );

  // Arbiter side: consumes commands, returns stall and read data.
  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdatavalid, readdata
  );
endinterface

// File: rtl/soc1_ram_arbiter.sv
// Two-master arbiter for a single-port byte-enabled RAM; optional RAM_ARB_ROUND_ROBIN_EN sets IDLE tie-break.
// Latency: one idle cycle IDLE->first accept, zero-bubble owner handover, read data one cycle after accept.
// Backpressure: waitrequest=1 for any master not owning the RAM; owner keeps it at most HOLD_MAX beats if contended.
module soc1_ram_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int HOLD_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  soc1_ram_arbiter_if.slave   m0,
  soc1_ram_arbiter_if.slave   m1,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] HOLD_CNT = 4'(HOLD_MAX);

  typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1} state_t;

  state_t            state_q, state_d;
  logic [3:0]        beat_cnt_q, beat_cnt_d;
  logic [1:0]        rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0] hold_addr_q;
  logic [BE_W-1:0]   hold_be_q;
  logic [DATA_W-1:0] hold_wdata_q;

  logic       req0, req1;
  logic       acc0, acc1;
  logic       wait0, wait1;
  logic       pick1;
  logic [3:0] beat_inc;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  // Saturating beat count as it would stand after this cycle's beat.
  assign beat_inc = (beat_cnt_q == HOLD_CNT) ? beat_cnt_q : beat_cnt_q + 4'd1;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;
  // On a tie in IDLE the master that did not own the RAM last goes first.
  assign pick1 = req1 & (~req0 | ~last_owner_q);
  assign last_owner_d = acc1 ? 1'b1 : (acc0 ? 1'b0 : last_owner_q);

  // Remember which master most recently had a beat accepted.
  always_ff @(posedge clk) begin
    if (reset) last_owner_q <= 1'b1;
    else       last_owner_q <= last_owner_d;
  end
`else
  // Fixed priority: m0 always wins a tie in IDLE.
  assign pick1 = req1 & ~req0;
`endif

  // Next-state, grant and beat-count logic.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    acc0       = 1'b0;
    acc1       = 1'b0;
    wait0      = 1'b1;
    wait1      = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) state_d = pick1 ? S_OWN1 : S_OWN0;
      end
      S_OWN0: begin
        wait0 = 1'b0;
        acc0  = req0;
        if (!req0) begin
          state_d = req1 ? S_OWN1 : S_IDLE;
        end else begin
          beat_cnt_d = beat_inc;
          if (beat_inc == HOLD_CNT && req1) state_d = S_OWN1;
        end
      end
      S_OWN1: begin
        wait1 = 1'b0;
        acc1  = req1;
        if (!req1) begin
          state_d = req0 ? S_OWN0 : S_IDLE;
        end else begin
          beat_cnt_d = beat_inc;
          if (beat_inc == HOLD_CNT && req0) state_d = S_OWN0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) beat_cnt_d = '0;
  end

  // Route the owner's command to the RAM; otherwise replay the last owner's values.
  always_comb begin
    ram_address    = hold_addr_q;
    ram_byteenable = hold_be_q;
    ram_writedata  = hold_wdata_q;
    if (state_q == S_OWN0) begin
      ram_address    = m0.address;
      ram_byteenable = m0.write ? m0.byteenable : {BE_W{1'b1}};
      ram_writedata  = m0.writedata;
    end else if (state_q == S_OWN1) begin
      ram_address    = m1.address;
      ram_byteenable = m1.write ? m1.byteenable : {BE_W{1'b1}};
      ram_writedata  = m1.writedata;
    end
  end

  // A read is pending only for a pure read (read+write counts as a write).
  assign rd_pend_d = {acc1 & m1.read & ~m1.write, acc0 & m0.read & ~m0.write};

  // Reset forces the command off and stalls both masters in the reset cycle itself.
  assign ram_chipselect   = (acc0 | acc1) & ~reset;
  assign ram_write        = ((acc0 & m0.write) | (acc1 & m1.write)) & ~reset;
  assign ram_clken        = 1'b1;
  assign m0.waitrequest   = wait0 | reset;
  assign m1.waitrequest   = wait1 | reset;
  assign m0.readdatavalid = rd_pend_q[0] & ~reset;
  assign m1.readdatavalid = rd_pend_q[1] & ~reset;
  assign m0.readdata      = ram_readdata;
  assign m1.readdata      = ram_readdata;

  // State, beat counter, read-pending flags and held RAM command fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      beat_cnt_q   <= '0;
      rd_pend_q    <= '0;
      hold_addr_q  <= '0;
      hold_be_q    <= '0;
      hold_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      rd_pend_q    <= rd_pend_d;
      hold_addr_q  <= ram_address;
      hold_be_q    <= ram_byteenable;
      hold_wdata_q <= ram_writedata;
    end
  end
endmodule

// File: tb/tb_soc1_ram_arbiter.sv
// Randomized and directed bench for soc1_ram_arbiter against a cycle-level reference model.
// Latency: model predicts grants, RAM strobes and read returns each cycle.
// Backpressure: requests are held until the DUT's waitrequest drops.
module tb_soc1_ram_arbiter;
  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata;

  soc1_ram_arbiter_if #(.ADDR_W(9), .DATA_W(32)) m0_bus ();
  soc1_ram_arbiter_if #(.ADDR_W(9), .DATA_W(32)) m1_bus ();

  soc1_ram_arbiter #(.ADDR_W(9), .DATA_W(32), .HOLD_MAX(HOLD)) dut (
    .clk(clk), .reset(reset), .m0(m0_bus), .m1(m1_bus),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata)
  );

  always #5 clk = ~clk;

  // RAM behaviour: registered address, byte-lane writes, q valid next cycle.
  logic [31:0] ram_mem [512];
  always @(posedge clk) begin
    if (ram_chipselect && ram_clken) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) ram_mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
      end else begin
        ram_readdata <= ram_mem[ram_address];
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus for the coming cycle.
  bit          s_rst;
  bit          s_rd [2];
  bit          s_wr [2];
  logic [8:0]  s_a  [2];
  logic [3:0]  s_be [2];
  logic [31:0] s_d  [2];

  // Reference model: who owns the RAM, how long, last accepted master, expected read returns.
  int          own = -1;
  int          run = 0;
  int          last = 1;
  bit          pend [2];
  logic [31:0] pend_d [2];
  logic [31:0] smem [512];
  int          dut_acc;

  task automatic clear_req();
    for (int i = 0; i < 2; i++) begin
      s_rd[i] = 0; s_wr[i] = 0;
    end
  endtask

  task automatic step();
    bit          req [2];
    int          acc;
    bit          npend [2];
    logic [31:0] npend_d [2];
    @(negedge clk);
    reset = s_rst;
    m0_bus.read = s_rd[0]; m0_bus.write = s_wr[0]; m0_bus.address = s_a[0];
    m0_bus.byteenable = s_be[0]; m0_bus.writedata = s_d[0];
    m1_bus.read = s_rd[1]; m1_bus.write = s_wr[1]; m1_bus.address = s_a[1];
    m1_bus.byteenable = s_be[1]; m1_bus.writedata = s_d[1];
    #1;
    for (int i = 0; i < 2; i++) req[i] = s_rd[i] | s_wr[i];
    dut_acc = -1;
    if (req[0] && !m0_bus.waitrequest) dut_acc = 0;
    else if (req[1] && !m1_bus.waitrequest) dut_acc = 1;
    if (s_rst) begin
      check("rst_wait0", 32'(m0_bus.waitrequest), 1);
      check("rst_wait1", 32'(m1_bus.waitrequest), 1);
      check("rst_rdv0", 32'(m0_bus.readdatavalid), 0);
      check("rst_rdv1", 32'(m1_bus.readdatavalid), 0);
      check("rst_cs", 32'(ram_chipselect), 0);
      check("rst_we", 32'(ram_write), 0);
      own = -1; run = 0; last = 1;
      pend[0] = 0; pend[1] = 0;
    end else begin
      acc = -1;
      if (own >= 0 && req[own]) acc = own;
      check("wait0", 32'(m0_bus.waitrequest), 32'(own != 0));
      check("wait1", 32'(m1_bus.waitrequest), 32'(own != 1));
      check("rdv0", 32'(m0_bus.readdatavalid), 32'(pend[0]));
      check("rdv1", 32'(m1_bus.readdatavalid), 32'(pend[1]));
      if (pend[0]) check("rdata0", m0_bus.readdata, pend_d[0]);
      if (pend[1]) check("rdata1", m1_bus.readdata, pend_d[1]);
      check("cs", 32'(ram_chipselect), 32'(acc >= 0));
      npend[0] = 0; npend[1] = 0;
      npend_d[0] = '0; npend_d[1] = '0;
      if (acc >= 0) begin
        check("we", 32'(ram_write), 32'(s_wr[acc]));
        check("addr", 32'(ram_address), 32'(s_a[acc]));
        if (s_wr[acc]) begin
          check("be", 32'(ram_byteenable), 32'(s_be[acc]));
          check("wdata", ram_writedata, s_d[acc]);
          for (int b = 0; b < 4; b++)
            if (s_be[acc][b]) smem[s_a[acc]][b*8 +: 8] = s_d[acc][b*8 +: 8];
        end else begin
          check("be_rd", 32'(ram_byteenable), 32'hF);
          npend[acc] = 1;
          npend_d[acc] = smem[s_a[acc]];
        end
        last = acc;
      end else begin
        check("we", 32'(ram_write), 0);
      end
      pend = npend;
      pend_d = npend_d;
      if (own < 0) begin
        if (req[0] && req[1]) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
          own = 1 - last;
`else
          own = 0;
`endif
        end else if (req[0]) own = 0;
        else if (req[1]) own = 1;
        run = 0;
      end else if (!req[own]) begin
        own = req[1-own] ? 1 - own : -1;
        run = 0;
      end else begin
        if (run < HOLD) run++;
        if (run == HOLD && req[1-own]) begin
          own = 1 - own;
          run = 0;
        end
      end
    end
  endtask

  // Issue one transfer on master m (other idle) and hold it until accepted.
  task automatic xfer(input int m, input bit w, input logic [8:0] a,
                      input logic [3:0] be, input logic [31:0] d);
    bit done = 0;
    clear_req();
    s_rst = 0;
    s_rd[m] = !w; s_wr[m] = w; s_a[m] = a; s_be[m] = be; s_d[m] = d;
    for (int k = 0; k < 20 && !done; k++) begin
      step();
      if (dut_acc == m) done = 1;
    end
    if (!done) check("xfer_timeout", 0, 1);
    clear_req();
  endtask

  task automatic idle(input int n);
    clear_req();
    s_rst = 0;
    for (int k = 0; k < n; k++) step();
  endtask

  int exp3 [13] = '{-1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
  int n_acc, n_rv;

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram_mem[i] = '0; smem[i] = '0;
    end
    ram_readdata = '0;
    for (int i = 0; i < 2; i++) begin
      s_a[i] = '0; s_be[i] = '0; s_d[i] = '0;
    end
    clear_req();
    pend[0] = 0; pend[1] = 0;
    pend_d[0] = '0; pend_d[1] = '0;

    s_rst = 1; step(); step();
    idle(2);

    // Write then read back one word.
    xfer(0, 1, 9'h005, 4'hF, 32'hDEADBEEF);
    xfer(0, 0, 9'h005, 4'hF, 32'h0);
    idle(1);
    check("t1_rdv", 32'(m0_bus.readdatavalid), 1);
    check("t1_data", m0_bus.readdata, 32'hDEADBEEF);
    idle(1);
    check("t1_rdv_once", 32'(m0_bus.readdatavalid), 0);

    // Partial byte-lane write merges with existing contents.
    xfer(0, 1, 9'h010, 4'hF, 32'hFFFFFFFF);
    xfer(0, 1, 9'h010, 4'h3, 32'h12345678);
    xfer(0, 0, 9'h010, 4'hF, 32'h0);
    idle(1);
    check("t2_data", m0_bus.readdata, 32'hFFFF5678);
    idle(2);

    // Both masters contend continuously from IDLE.
    s_rst = 0;
    for (int i = 0; i < 2; i++) begin
      s_wr[i] = 1; s_a[i] = 9'(32 + i); s_be[i] = 4'hF;
    end
    for (int k = 0; k < 13; k++) begin
      s_d[0] = $urandom; s_d[1] = $urandom;
      step();
      check($sformatf("t3_acc%0d", k), 32'(dut_acc), 32'(exp3[k]));
    end
    idle(2);

    // m1 alone issues 10 reads back to back.
    n_acc = 0; n_rv = 0;
    clear_req();
    for (int k = 0; k < 13; k++) begin
      s_rd[1] = (n_acc < 10);
      s_a[1] = 9'(n_acc);
      step();
      if (k == 0) check("t4_wait_first", 32'(m1_bus.waitrequest), 1);
      if (dut_acc == 1) n_acc++;
      if (m1_bus.readdatavalid) n_rv++;
      if (k >= 1 && k <= 10) check($sformatf("t4_acc%0d", k), 32'(dut_acc), 1);
      if (k >= 2 && k <= 11) check($sformatf("t4_rdv%0d", k), 32'(m1_bus.readdatavalid), 1);
    end
    check("t4_acc_count", 32'(n_acc), 10);
    check("t4_rdv_count", 32'(n_rv), 10);
    idle(2);

    // Reset right after a read accept cancels the return.
    xfer(0, 0, 9'h005, 4'hF, 32'h0);
    s_rst = 1; step();
    check("t5_rdv_rst", 32'(m0_bus.readdatavalid), 0);
    check("t5_wait0", 32'(m0_bus.waitrequest), 1);
    check("t5_wait1", 32'(m1_bus.waitrequest), 1);
    s_rst = 0;
    s_rd[0] = 1; s_a[0] = 9'h005;
    step();
    check("t5_rdv_after", 32'(m0_bus.readdatavalid), 0);
    check("t5_idle_wait", 32'(m0_bus.waitrequest), 1);
    idle(2);

    // Tie after m0 was last served.
    xfer(0, 1, 9'h007, 4'hF, 32'hA5A5A5A5);
    idle(2);
    s_rd[0] = 1; s_rd[1] = 1; s_a[0] = 9'h007; s_a[1] = 9'h005;
    step();
    step();
`ifdef RAM_ARB_ROUND_ROBIN_EN
    check("t6_tie", 32'(dut_acc), 1);
`else
    check("t6_tie", 32'(dut_acc), 0);
`endif
    idle(3);

    // Random traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      s_rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 2; i++) begin
        s_rd[i] = ($urandom_range(0, 2) != 0);
        s_wr[i] = ($urandom_range(0, 2) == 0);
        s_a[i]  = 9'($urandom_range(0, 15));
        s_be[i] = 4'($urandom);
        s_d[i]  = $urandom;
      end
      step();
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end
endmodule
